// File: rtl/pipo_bank.sv
// pipo_bank: a bank of DEPTH parallel-in/parallel-out registers, WIDTH bits each.
// It holds operands, partial products and counters for the multiplier datapath.
// One write port updates one entry per cycle in LOAD, ADD, DEC or SHR mode.
// Two combinational read ports are provided, along with a zero flag on port A
// and a sticky overflow/borrow flag.
//
// Ports
//   clk      in   1      clock, all state changes on posedge
//   rst_n    in   1      asynchronous active-low reset (entries and ovf -> 0)
//   clr      in   1      synchronous clear of all entries and ovf, overrides we
//   we       in   1      write enable for entry waddr
//   waddr    in   AW     write/update address; writes to waddr >= DEPTH are dropped
//   mode     in   2      00 LOAD, 01 ADD, 10 DEC, 11 SHR
//   din      in   WIDTH  load data / addend
//   raddr_a  in   AW     read address A
//   dout_a   out  WIDTH  entry raddr_a, or 0 when out of range
//   zero_a   out  1      dout_a == 0
//   raddr_b  in   AW     read address B
//   dout_b   out  WIDTH  entry raddr_b, or 0 when out of range
//   ovf      out  1      sticky carry/borrow flag
//   ovf_clr  in   1      synchronous clear of ovf; a same-cycle set wins
module pipo_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] dout_a,
  output logic             zero_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] dout_b,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

  // One extra bit so DEPTH == 2**AW is representable in the range compare.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ovf;

  logic             w_waddr_ok;
  logic             w_ra_ok;
  logic             w_rb_ok;
  logic             w_wr;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH:0]   w_sum;
  logic             w_set_ovf;

  assign w_waddr_ok = ({1'b0, waddr}   < DEPTH_L);
  assign w_ra_ok    = ({1'b0, raddr_a} < DEPTH_L);
  assign w_rb_ok    = ({1'b0, raddr_b} < DEPTH_L);
  assign w_wr       = we && w_waddr_ok;

  // Reads come straight from the register outputs, so a same-cycle read of
  // the entry being written returns the pre-edge value.
  assign dout_a = w_ra_ok ? r_mem[raddr_a] : '0;
  assign dout_b = w_rb_ok ? r_mem[raddr_b] : '0;
  assign zero_a = (dout_a == '0);
  assign ovf    = r_ovf;

  assign w_cur  = w_waddr_ok ? r_mem[waddr] : '0;
  assign w_sum  = {1'b0, w_cur} + {1'b0, din};

  always_comb begin
    w_next    = w_cur;
    w_set_ovf = 1'b0;
    case (mode)
      MODE_LOAD: w_next = din;
      MODE_ADD: begin
        w_next    = w_sum[WIDTH-1:0];
        w_set_ovf = w_sum[WIDTH];
      end
      MODE_DEC: begin
        w_next    = w_cur - {{(WIDTH-1){1'b0}}, 1'b1};
        w_set_ovf = (w_cur == '0);
      end
      MODE_SHR: w_next = {1'b0, w_cur[WIDTH-1:1]};
      default:  w_next = w_cur;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_mem[waddr] <= w_next;
      // A fresh carry/borrow beats ovf_clr in the same cycle.
      if (w_wr && w_set_ovf) r_ovf <= 1'b1;
      else if (ovf_clr)      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipo_bank.sv
module tb_pipo_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, we, ovf_clr;
  logic [1:0]  waddr, raddr_a, raddr_b, mode;
  logic [15:0] din;

  logic [15:0] dout_a, dout_b, d3_dout_a, d3_dout_b;
  logic        zero_a, ovf, d3_zero_a, d3_ovf;

  localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, DEC = 2'b10, SHR = 2'b11;

  always #5 clk = ~clk;

  pipo_bank #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .mode(mode),
    .din(din), .raddr_a(raddr_a), .dout_a(dout_a), .zero_a(zero_a),
    .raddr_b(raddr_b), .dout_b(dout_b), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  pipo_bank #(.WIDTH(16), .DEPTH(3), .AW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .mode(mode),
    .din(din), .raddr_a(raddr_a), .dout_a(d3_dout_a), .zero_a(d3_zero_a),
    .raddr_b(raddr_b), .dout_b(d3_dout_b), .ovf(d3_ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    string       name;
    bit          sel3;
    logic [15:0] a;
    logic [15:0] b;
    logic        z;
    logic        o;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  // Monitor: pops every queued expectation when the sample strobe fires.
  initial begin
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        exp_t e;
        logic [15:0] aa, bb;
        logic        zz, oo;
        e  = q.pop_front();
        aa = e.sel3 ? d3_dout_a : dout_a;
        bb = e.sel3 ? d3_dout_b : dout_b;
        zz = e.sel3 ? d3_zero_a : zero_a;
        oo = e.sel3 ? d3_ovf    : ovf;
        checks++;
        if (aa !== e.a || bb !== e.b || zz !== e.z || oo !== e.o) begin
          failures++;
          $display("FAIL %s: got a=%h b=%h zero=%b ovf=%b expected a=%h b=%h zero=%b ovf=%b",
                   e.name, aa, bb, zz, oo, e.a, e.b, e.z, e.o);
        end
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      failures++;
      $display("FAIL timeout: test sequence did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic expect_rd(input string name, input bit sel3, input logic [1:0] ra,
                           input logic [1:0] rb, input logic [15:0] a,
                           input logic [15:0] b, input logic o);
    exp_t e;
    raddr_a = ra;
    raddr_b = rb;
    #1;
    e.name = name; e.sel3 = sel3; e.a = a; e.b = b; e.z = (a == 16'h0); e.o = o;
    q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] wa, input logic [1:0] md, input logic [15:0] d);
    we = 1'b1; waddr = wa; mode = md; din = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; ovf_clr = 1'b0;
    waddr = '0; raddr_a = '0; raddr_b = '0; mode = LOAD; din = '0;
    #1;
    checks++;
    if (dout_a !== 16'h0000 || dout_b !== 16'h0000 || zero_a !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_direct: got a=%h b=%h zero=%b ovf=%b", dout_a, dout_b, zero_a, ovf);
    end
    expect_rd("reset_state", 0, 2'd0, 2'd1, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: async reset mid-stream, in-flight write discarded
    op(2'd0, LOAD, 16'h1111);
    op(2'd1, LOAD, 16'h2222);
    op(2'd2, LOAD, 16'hFFFF);
    op(2'd2, ADD,  16'h0001);
    expect_rd("preload", 0, 2'd0, 2'd1, 16'h1111, 16'h2222, 1'b1);
    we = 1'b1; waddr = 2'd0; mode = LOAD; din = 16'h5555;
    rst_n = 1'b0;
    expect_rd("async_reset", 0, 2'd0, 2'd1, 16'h0000, 16'h0000, 1'b0);
    tick();
    expect_rd("reset_discard", 0, 2'd0, 2'd2, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    din = 16'h0ABC;
    tick();
    we = 1'b0;
    expect_rd("first_write_after_rst", 0, 2'd0, 2'd1, 16'h0ABC, 16'h0000, 1'b0);

    // 2: accumulate chain with same-cycle old-value read
    op(2'd0, LOAD, 16'h00FF);
    we = 1'b1; waddr = 2'd0; mode = ADD; din = 16'h0001;
    expect_rd("add_same_cycle_0", 0, 2'd0, 2'd0, 16'h00FF, 16'h00FF, 1'b0);
    tick();
    expect_rd("add_same_cycle_1", 0, 2'd0, 2'd0, 16'h0100, 16'h0100, 1'b0);
    tick();
    tick();
    we = 1'b0;
    expect_rd("add_chain", 0, 2'd0, 2'd1, 16'h0102, 16'h0000, 1'b0);

    // 3: add carry, sticky through LOAD, ovf_clr
    op(2'd1, LOAD, 16'hFFFF);
    op(2'd1, ADD,  16'h0002);
    expect_rd("add_carry", 0, 2'd1, 2'd0, 16'h0001, 16'h0102, 1'b1);
    op(2'd1, LOAD, 16'h0005);
    expect_rd("ovf_sticky", 0, 2'd1, 2'd0, 16'h0005, 16'h0102, 1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    expect_rd("ovf_clr", 0, 2'd1, 2'd0, 16'h0005, 16'h0102, 1'b0);

    // 4: decrement to zero, borrow, set beats ovf_clr
    op(2'd2, LOAD, 16'h0003);
    op(2'd2, DEC,  16'hAAAA);
    expect_rd("dec_1", 0, 2'd2, 2'd1, 16'h0002, 16'h0005, 1'b0);
    op(2'd2, DEC,  16'h0000);
    op(2'd2, DEC,  16'h0000);
    expect_rd("dec_zero", 0, 2'd2, 2'd1, 16'h0000, 16'h0005, 1'b0);
    op(2'd2, DEC,  16'h0000);
    expect_rd("dec_borrow", 0, 2'd2, 2'd1, 16'hFFFF, 16'h0005, 1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    expect_rd("ovf_clr_2", 0, 2'd2, 2'd1, 16'hFFFF, 16'h0005, 1'b0);
    op(2'd2, LOAD, 16'h0000);
    ovf_clr = 1'b1;
    op(2'd2, DEC, 16'h0000);
    ovf_clr = 1'b0;
    expect_rd("set_beats_clr", 0, 2'd2, 2'd1, 16'hFFFF, 16'h0005, 1'b1);

    // 5: shift right, then clr overrides write
    op(2'd3, LOAD, 16'h8001);
    op(2'd3, SHR,  16'hFFFF);
    expect_rd("shr_1", 0, 2'd3, 2'd2, 16'h4000, 16'hFFFF, 1'b1);
    op(2'd3, SHR,  16'hFFFF);
    expect_rd("shr_2", 0, 2'd3, 2'd0, 16'h2000, 16'h0102, 1'b1);
    clr = 1'b1; raddr_b = 2'd3;
    op(2'd3, LOAD, 16'h1234);
    clr = 1'b0;
    expect_rd("clr_all_03", 0, 2'd0, 2'd3, 16'h0000, 16'h0000, 1'b0);
    expect_rd("clr_all_12", 0, 2'd1, 2'd2, 16'h0000, 16'h0000, 1'b0);

    // 6: DEPTH=3 instance drops out-of-range writes, out-of-range read is 0
    op(2'd0, LOAD, 16'hAAAA);
    op(2'd1, LOAD, 16'hBBBB);
    op(2'd2, LOAD, 16'hCCCC);
    op(2'd3, LOAD, 16'h1234);
    op(2'd3, ADD,  16'hFFFF);
    expect_rd("d3_oor_read", 1, 2'd3, 2'd2, 16'h0000, 16'hCCCC, 1'b0);
    expect_rd("d3_entries", 1, 2'd0, 2'd1, 16'hAAAA, 16'hBBBB, 1'b0);
    expect_rd("d4_entry3", 0, 2'd3, 2'd2, 16'h1233, 16'hCCCC, 1'b1);
    op(2'd3, DEC, 16'h0000);
    expect_rd("d3_oor_dec", 1, 2'd2, 2'd3, 16'hCCCC, 16'h0000, 1'b0);

    #5;
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
